// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and helpers for the UART receive deserialiser.
//               Holds the receiver state encoding, the idle line level, the
//               legal data-width bounds and the parity helper.
// Revision    : 1.0  initial release
// ============================================================================
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic IDLE_LEVEL    = 1'b1;
  localparam int   DATA_BITS_MIN = 5;
  localparam int   DATA_BITS_MAX = 9;

  // XOR of the data word, inverted for odd parity. Zero-extended inputs are
  // harmless because extra zero bits do not change the XOR.
  function automatic logic parity_of(input logic [DATA_BITS_MAX-1:0] data,
                                     input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deser_if
// Description : Valid/ready output channel of the UART receive deserialiser.
//   data_out   : received word, LSB = first data bit on the wire
//   data_valid : data_out and the error flags are valid
//   data_ready : consumer accepts the word when data_valid && data_ready
//   parity_err : parity mismatch for the held word
//   frame_err  : a stop bit was sampled low for the held word
//   master = receiver side, slave = consumer side.
// Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_deser_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    output data_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_bit_sampler
// Description : Front end of the UART receiver. Synchronises the RX line,
//               runs the per-bit tick counter, detects the start edge and
//               produces one bit decision per bit period.
//   baud_clk   in  oversampled clock
//   rst_n      in  asynchronous active-low reset
//   data_tx    in  raw serial line
//   restart    in  state is changing; tick counter restarts at 0
//   in_start   in  receiver is in START (mid-bit at half period)
//   bit_val    out sampled bit value
//   bit_strobe out bit_val is valid this cycle
//   fall_edge  out synchronised line went high->low
// Build option: UART_RX_MAJORITY_EN selects a 3-sample majority vote that
//               resolves one tick after mid-bit.
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic baud_clk,
  input  logic rst_n,
  input  logic data_tx,
  input  logic restart,
  input  logic in_start,
  output logic bit_val,
  output logic bit_strobe,
  output logic fall_edge
);

  localparam int                TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] MID_START = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

  logic              sync1;
  logic              rx_s;
  logic              rx_d;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] mid_tick;
  logic              at_mid;

  // Later bits are one full period after the realigned START sample, so
  // their mid-bit is the last tick of the period.
  assign mid_tick  = in_start ? MID_START : LAST_TICK;
  assign at_mid    = (tick_cnt == mid_tick);
  assign fall_edge = rx_d & ~rx_s;

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= IDLE_LEVEL;
      rx_s     <= IDLE_LEVEL;
      rx_d     <= IDLE_LEVEL;
      tick_cnt <= '0;
    end else begin
      sync1 <= data_tx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
      if (restart || tick_cnt == LAST_TICK) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic vote_a;
  logic vote_b;
  logic armed;

  // Samples at mid-1 and mid are held; the third is the live rx_s one tick
  // later, which is also when the decision is issued.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_a <= IDLE_LEVEL;
      vote_b <= IDLE_LEVEL;
      armed  <= 1'b0;
    end else begin
      if (tick_cnt == mid_tick - TICK_W'(1)) begin
        vote_a <= rx_s;
      end
      if (at_mid) begin
        vote_b <= rx_s;
      end
      armed <= at_mid & ~restart;
    end
  end

  assign bit_strobe = armed;
  assign bit_val    = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
  assign bit_strobe = at_mid;
  assign bit_val    = rx_s;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deser
// Description : Parametrised UART receive deserialiser on an oversampled
//               clock. Detects start bits, samples each bit mid-period,
//               checks parity and stop bits and presents the word through a
//               valid/ready output register.
//   baud_clk in  oversampled clock (OVERSAMPLE ticks per bit)
//   rst_n    in  asynchronous active-low reset
//   data_tx  in  serial line, idle high
//   busy     out high whenever a frame is in progress
//   overrun  out one-cycle pulse: frame dropped because the word was held
//   rx_if    master modport: data_out/data_valid/data_ready/parity_err/
//            frame_err
// Build option: UART_RX_MAJORITY_EN enables 3-sample majority voting.
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx_deser
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                   baud_clk,
  input  logic                   rst_n,
  input  logic                   data_tx,
  output logic                   busy,
  output logic                   overrun,
  uart_rx_deser_if.master        rx_if
);

  localparam int CNT_W = $clog2(DATA_BITS);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_cfg_check
    $error("uart_rx_deser: DATA_BITS out of range");
  end

  rx_state_t            state;
  rx_state_t            next_state;
  logic                 restart;
  logic                 bit_val;
  logic                 bit_strobe;
  logic                 fall_edge;
  logic [DATA_BITS-1:0] shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 par_err_c;
  logic                 frm_err_c;
  logic                 last_data;
  logic                 last_stop;
  logic                 frame_done;
  logic                 frm_err_now;
  logic                 load;

  uart_rx_bit_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .baud_clk   (baud_clk),
    .rst_n      (rst_n),
    .data_tx    (data_tx),
    .restart    (restart),
    .in_start   (state == START),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe),
    .fall_edge  (fall_edge)
  );

  assign last_data = (bit_cnt == CNT_W'(DATA_BITS - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  // State register
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fall_edge) next_state = START;
      START:   if (bit_strobe) next_state = bit_val ? IDLE : DATA;
      DATA:    if (bit_strobe && last_data)
                 next_state = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_strobe) next_state = STOP;
      STOP:    if (bit_strobe && last_stop) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs. The frame completes at the last stop mid-sample so the
  // receiver is back in IDLE in time to catch a start bit that follows
  // immediately.
  always_comb begin
    busy        = (state != IDLE);
    restart     = (next_state != state);
    frame_done  = (state == STOP) && bit_strobe && last_stop;
    frm_err_now = frm_err_c | ~bit_val;
    load        = frame_done && (!rx_if.data_valid || rx_if.data_ready);
  end

  // Frame datapath: shift register, counters and error candidates.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '1;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par_err_c <= 1'b0;
      frm_err_c <= 1'b0;
    end else if (bit_strobe) begin
      case (state)
        START: begin
          bit_cnt   <= '0;
          stop_cnt  <= 1'b0;
          par_err_c <= 1'b0;
          frm_err_c <= 1'b0;
        end
        DATA: begin
          // LSB arrives first: shift in at the top, move right.
          shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: begin
          par_err_c <= parity_of(DATA_BITS_MAX'(shreg), PARITY_ODD != 0) ^ bit_val;
        end
        STOP: begin
          stop_cnt <= stop_cnt + 1'b1;
          if (!bit_val) frm_err_c <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output register with valid/ready handshake.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_if.data_out   <= '0;
      rx_if.data_valid <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      overrun <= frame_done && rx_if.data_valid && !rx_if.data_ready;
      if (load) begin
        rx_if.data_out   <= shreg;
        rx_if.parity_err <= par_err_c;
        rx_if.frame_err  <= frm_err_now;
        rx_if.data_valid <= 1'b1;
      end else if (rx_if.data_valid && rx_if.data_ready) begin
        rx_if.data_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_deser
// Description : Self-checking bench for uart_rx_deser. Frames are built bit
//               by bit on the wire; the expected word and flags for every
//               frame that should be delivered are queued, and a monitor
//               compares them at each accepted handshake.
// Build option: UART_RX_MAJORITY_EN adds a mid-bit glitch frame.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_deser;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int PARITY_EN  = 1;
  localparam int PARITY_ODD = 0;
  localparam int STOP_BITS  = 1;

  logic baud_clk    = 1'b0;
  logic rst_n       = 1'b0;
  logic data_tx     = 1'b1;
  logic ready_fixed = 1'b1;
  logic rand_ready  = 1'b0;
  logic rnd_bit     = 1'b1;
  logic busy;
  logic overrun;

  uart_rx_deser_if #(.DATA_BITS(DATA_BITS)) rx_if ();
  assign rx_if.data_ready = rand_ready ? rnd_bit : ready_fixed;

  uart_rx_deser #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE),
    .PARITY_EN  (PARITY_EN),
    .PARITY_ODD (PARITY_ODD),
    .STOP_BITS  (STOP_BITS)
  ) dut (
    .baud_clk (baud_clk),
    .rst_n    (rst_n),
    .data_tx  (data_tx),
    .busy     (busy),
    .overrun  (overrun),
    .rx_if    (rx_if)
  );

  always #5 baud_clk = ~baud_clk;

  int checks   = 0;
  int passes   = 0;
  int ovr_seen = 0;
  int ovr_exp  = 0;
  logic [DATA_BITS+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Random consumer readiness
  initial begin
    forever begin
      @(posedge baud_clk);
      #2;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  // Monitor / scoreboard
  initial begin
    logic                 prev_hs;
    logic [DATA_BITS+1:0] e;
    prev_hs = 1'b0;
    forever begin
      @(negedge baud_clk);
      if (!rst_n) begin
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) check("valid_after_accept", rx_if.data_valid, 0);
        if (overrun) ovr_seen++;
        prev_hs = rx_if.data_valid && rx_if.data_ready;
        if (prev_hs) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_word: got 0x%0h expected no word", rx_if.data_out);
          end else begin
            e = exp_q.pop_front();
            check("data_out",   rx_if.data_out,   e[DATA_BITS+1:2]);
            check("parity_err", rx_if.parity_err, e[1]);
            check("frame_err",  rx_if.frame_err,  e[0]);
          end
        end
      end
    end
  end

  task automatic hold(input logic v, input int ticks);
    data_tx = v;
    repeat (ticks) @(posedge baud_clk);
    #1;
  endtask

  // Send one frame. stop_low marks stop bits driven low; expect queues the
  // word the receiver should deliver.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit flip,
                            input logic [1:0] stop_low, input int gap, input bit expect_word);
    logic [1:0] smask;
    smask = (STOP_BITS == 2) ? 2'b11 : 2'b01;
    if (expect_word)
      exp_q.push_back({d, flip && (PARITY_EN != 0), |(stop_low & smask)});
    hold(1'b0, OVERSAMPLE);
    for (int i = 0; i < DATA_BITS; i++) hold(d[i], OVERSAMPLE);
    if (PARITY_EN != 0) hold((^d) ^ (PARITY_ODD != 0) ^ flip, OVERSAMPLE);
    for (int s = 0; s < STOP_BITS; s++) hold(!stop_low[s], OVERSAMPLE);
    if (gap > 0) hold(1'b1, gap * OVERSAMPLE);
  endtask

`ifdef UART_RX_MAJORITY_EN
  // All-ones word with a one-tick low glitch in the middle of data bit 3.
  task automatic send_glitch_ones();
    logic [DATA_BITS-1:0] d;
    d = '1;
    exp_q.push_back({d, 1'b0, 1'b0});
    hold(1'b0, OVERSAMPLE);
    for (int i = 0; i < DATA_BITS; i++) begin
      if (i == 3) begin
        hold(1'b1, OVERSAMPLE / 2);
        hold(1'b0, 1);
        hold(1'b1, OVERSAMPLE / 2 - 1);
      end else begin
        hold(1'b1, OVERSAMPLE);
      end
    end
    if (PARITY_EN != 0) hold((^d) ^ (PARITY_ODD != 0), OVERSAMPLE);
    hold(1'b1, (STOP_BITS + 2) * OVERSAMPLE);
  endtask
`endif

  initial begin
    int wait_cnt;
    // Reset values
    repeat (3) @(posedge baud_clk);
    #1;
    check("rst_data_valid", rx_if.data_valid, 0);
    check("rst_data_out",   rx_if.data_out,   0);
    check("rst_parity_err", rx_if.parity_err, 0);
    check("rst_frame_err",  rx_if.frame_err,  0);
    check("rst_overrun",    overrun,          0);
    check("rst_busy",       busy,             0);
    rst_n = 1'b1;
    hold(1'b1, 2 * OVERSAMPLE);

    // Directed frames
    send_frame(DATA_BITS'(8'hA5), 1'b0, 2'b00, 2, 1'b1);
    send_frame(DATA_BITS'(8'h3C), 1'b1, 2'b00, 2, 1'b1);
    send_frame(DATA_BITS'(8'h55), 1'b0, (STOP_BITS == 2) ? 2'b10 : 2'b01, 0, 1'b1);

    // Break: line stays low; no new frame without a fresh falling edge
    hold(1'b0, 20 * OVERSAMPLE);
    check("break_busy", busy, 0);
    hold(1'b1, 2 * OVERSAMPLE);

    // Short glitch is rejected as a false start
    hold(1'b0, 3);
    data_tx = 1'b1;
    check("glitch_busy_start", busy, 1);
    hold(1'b1, 2 * OVERSAMPLE);
    check("glitch_busy_idle", busy, 0);
    check("glitch_no_valid", rx_if.data_valid, 0);

`ifdef UART_RX_MAJORITY_EN
    send_glitch_ones();
`endif

    // Overrun: consumer stalled across two frames
    ready_fixed = 1'b0;
    send_frame(DATA_BITS'(8'h11), 1'b0, 2'b00, 0, 1'b1);
    send_frame(DATA_BITS'(8'h22), 1'b0, 2'b00, 1, 1'b0);
    ovr_exp++;
    check("ovr_held_word",  rx_if.data_out,   DATA_BITS'(8'h11));
    check("ovr_held_valid", rx_if.data_valid, 1);
    check("ovr_pulses",     ovr_seen,         ovr_exp);
    ready_fixed = 1'b1;
    repeat (3) @(posedge baud_clk);
    #1;
    check("ovr_released", rx_if.data_valid, 0);

    // Reset in the middle of a frame (during bit 4 of 0x81)
    hold(1'b0, OVERSAMPLE);
    for (int i = 0; i < 4; i++) hold(i == 0, OVERSAMPLE);
    hold(1'b0, OVERSAMPLE / 2);
    data_tx = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(posedge baud_clk);
    #1;
    check("midrst_valid", rx_if.data_valid, 0);
    check("midrst_busy",  busy,             0);
    rst_n = 1'b1;
    hold(1'b1, 2 * OVERSAMPLE);
    send_frame(DATA_BITS'(8'h7E), 1'b0, 2'b00, 2, 1'b1);

    // Randomised frames with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [DATA_BITS-1:0] d;
      logic [1:0]           sl;
      bit                   fl;
      int                   gap;
      d   = DATA_BITS'($urandom);
      fl  = ($urandom_range(0, 3) == 0);
      sl  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      gap = $urandom_range(0, 3);
      if (sl != 2'b00 && gap == 0) gap = 1;
      send_frame(d, fl, sl, gap, 1'b1);
    end
    rand_ready  = 1'b0;
    ready_fixed = 1'b1;

    // Drain
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 2000) begin
      @(posedge baud_clk);
      wait_cnt++;
    end
    #1;
    check("queue_drained",   exp_q.size(), 0);
    check("overrun_total",   ovr_seen,     ovr_exp);
    check("final_busy",      busy,         0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
